// File: rtl/dmem_arbiter_if.sv
// Data-memory arbitration bus: two requesters plus the memory port.
// master = requesters and memory model side, slave = the arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output mem_dout,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_we, mem_addr, mem_din
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  mem_dout,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin data-memory arbiter with a bounded ownership
// lock for requester 1; single-cycle issue, read data returned one cycle later.
module dmem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);
  localparam logic [3:0] LOCK_MAX = 4'd8;

  typedef enum logic {IDLE, OWN1_LOCKED} arbState_e;

  arbState_e         state, stateNxt;
  logic [3:0]        lockCnt, lockCntNxt;
  logic              lastGnt;
  logic              gnt0, gnt1, grant, lockHold;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr, addrQ;
  logic [DATA_W-1:0] selDin, dinQ;
  logic              rdPend0, rdPend1, rv0, rv1;
  logic [DATA_W-1:0] rdataQ0, rdataQ1;

  // lockHold: requester 1 keeps the port while it asks and the budget lasts
  always_comb begin
    stateNxt   = state;
    lockCntNxt = lockCnt;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    lockHold   = (state == OWN1_LOCKED) && bus.m1_req && bus.m1_lock && (lockCnt < LOCK_MAX);
    if (!rst) begin
      if (lockHold) begin
        gnt1 = 1'b1;
      end else if (bus.m0_req && bus.m1_req) begin
        gnt0 = lastGnt;
        gnt1 = ~lastGnt;
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
    end
    case (state)
      IDLE: begin
        if (gnt1 && bus.m1_lock) begin
          stateNxt   = OWN1_LOCKED;
          lockCntNxt = 4'd1;
        end
      end
      OWN1_LOCKED: begin
        if (lockHold) begin
          lockCntNxt = lockCnt + 4'd1;
        end else begin
          stateNxt   = IDLE;
          lockCntNxt = 4'd0;
        end
      end
      default: begin
        stateNxt   = IDLE;
        lockCntNxt = 4'd0;
      end
    endcase
  end

  assign grant   = gnt0 | gnt1;
  assign selWe   = gnt1 ? bus.m1_we    : bus.m0_we;
  assign selAddr = gnt1 ? bus.m1_addr  : bus.m0_addr;
  assign selDin  = gnt1 ? bus.m1_wdata : bus.m0_wdata;

  assign bus.m0_gnt   = gnt0;
  assign bus.m1_gnt   = gnt1;
  assign bus.mem_we   = grant & selWe;
  assign bus.mem_addr = grant ? selAddr : addrQ;
  assign bus.mem_din  = grant ? selDin  : dinQ;

  // Reset in the response cycle kills a pending read's rvalid
  assign rv0 = rdPend0 & ~rst;
  assign rv1 = rdPend1 & ~rst;
  assign bus.m0_rvalid = rv0;
  assign bus.m1_rvalid = rv1;
  assign bus.m0_rdata  = rv0 ? bus.mem_dout : rdataQ0;
  assign bus.m1_rdata  = rv1 ? bus.mem_dout : rdataQ1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lockCnt <= 4'd0;
      lastGnt <= 1'b1;
      addrQ   <= '0;
      dinQ    <= '0;
      rdPend0 <= 1'b0;
      rdPend1 <= 1'b0;
      rdataQ0 <= '0;
      rdataQ1 <= '0;
    end else begin
      state   <= stateNxt;
      lockCnt <= lockCntNxt;
      if (grant) begin
        lastGnt <= gnt1;
        addrQ   <= selAddr;
        dinQ    <= selDin;
      end
      rdPend0 <= gnt0 & ~bus.m0_we;
      rdPend1 <= gnt1 & ~bus.m1_we;
      if (rv0) rdataQ0 <= bus.mem_dout;
      if (rv1) rdataQ1 <= bus.mem_dout;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts each
// cycle's grant, memory port and read return; a negedge monitor compares.
module tb_dmem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Memory device: synchronous read, one-cycle latency
  logic [DW-1:0] devMem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_we) devMem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= devMem[bus.mem_addr];
  end

  typedef struct {
    logic [1:0]    gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [1:0]    rv;
    logic [DW-1:0] rd0, rd1;
  } exp_t;

  exp_t expQ[$];
  int   gntLog[$];
  int   checks = 0, errors = 0;
  int   wait0 = 0, wait1 = 0, maxWait = 0;

  // Reference model state
  logic [DW-1:0] refMem [0:(1<<AW)-1];
  bit            mLastIsM1 = 1'b1;
  int            mRun = 0, mPend = 0, lastW = 0;
  logic [DW-1:0] mPendData = '0, mHold0 = '0, mHold1 = '0, mDin = '0;
  logic [AW-1:0] mAddr = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Predict the current cycle, queue it, then advance the model across the edge
  task automatic tick();
    exp_t e;
    int   w;
    e.rv  = 2'b00;
    if (!rst && mPend == 1) e.rv[0] = 1'b1;
    if (!rst && mPend == 2) e.rv[1] = 1'b1;
    e.rd0 = e.rv[0] ? mPendData : mHold0;
    e.rd1 = e.rv[1] ? mPendData : mHold1;
    w = 0;
    if (!rst) begin
      if (mRun > 0 && mRun < 8 && bus.m1_req && bus.m1_lock) w = 2;
      else if (bus.m0_req && bus.m1_req) w = mLastIsM1 ? 1 : 2;
      else if (bus.m0_req) w = 1;
      else if (bus.m1_req) w = 2;
    end
    e.gnt = (w == 1) ? 2'b01 : (w == 2) ? 2'b10 : 2'b00;
    e.we  = (w == 1) ? bus.m0_we : (w == 2) ? bus.m1_we : 1'b0;
    if (w == 1) begin mAddr = bus.m0_addr; mDin = bus.m0_wdata; end
    if (w == 2) begin mAddr = bus.m1_addr; mDin = bus.m1_wdata; end
    e.addr = mAddr;
    e.din  = mDin;
    expQ.push_back(e);
    if (rst) begin
      mLastIsM1 = 1'b1; mRun = 0; mPend = 0;
      mHold0 = '0; mHold1 = '0; mAddr = '0; mDin = '0;
    end else begin
      if (e.rv[0]) mHold0 = mPendData;
      if (e.rv[1]) mHold1 = mPendData;
      mPend = 0;
      if (w != 0) begin
        mLastIsM1 = (w == 2);
        if (e.we) refMem[mAddr] = mDin;
        else begin mPend = w; mPendData = refMem[mAddr]; end
      end
      if (mRun == 8) mRun = 0;
      else if (w == 2 && bus.m1_lock) mRun++;
      else mRun = 0;
    end
    lastW = w;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic we0, input int a0, input logic [DW-1:0] d0,
                       input logic r1, input logic we1, input int a1, input logic [DW-1:0] d1,
                       input logic lk);
    bus.m0_req = r0; bus.m0_we = we0; bus.m0_addr = AW'(a0); bus.m0_wdata = d0;
    bus.m1_req = r1; bus.m1_we = we1; bus.m1_addr = AW'(a1); bus.m1_wdata = d1;
    bus.m1_lock = lk;
  endtask

  task automatic logChk(input string nm, input string ex);
    string s = "";
    foreach (gntLog[i]) s = {s, $sformatf("%0d", gntLog[i])};
    checks++;
    if (s != ex) begin
      errors++;
      $display("FAIL %s: grant order %s want %s", nm, s, ex);
    end
    gntLog.delete();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("gnt",    {bus.m1_gnt, bus.m0_gnt}, e.gnt);
      chk("mutex",  bus.m1_gnt & bus.m0_gnt, 1'b0);
      chk("mem_we", bus.mem_we, e.we);
      chk("mem_addr", bus.mem_addr, e.addr);
      chk("mem_din",  bus.mem_din, e.din);
      chk("rvalid", {bus.m1_rvalid, bus.m0_rvalid}, e.rv);
      chk("m0_rdata", bus.m0_rdata, e.rd0);
      chk("m1_rdata", bus.m1_rdata, e.rd1);
      gntLog.push_back(int'({bus.m1_gnt, bus.m0_gnt}));
      wait0 = (bus.m0_req && !bus.m0_gnt) ? wait0 + 1 : 0;
      wait1 = (bus.m1_req && !bus.m1_gnt) ? wait1 + 1 : 0;
      if (wait0 > maxWait) maxWait = wait0;
      if (wait1 > maxWait) maxWait = wait1;
    end
  end

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < (1 << AW); i++) begin
      v = $urandom;
      devMem[i] = v;
      refMem[i] = v;
    end
    devMem[9'h010] = 32'hDEADBEEF;
    refMem[9'h010] = 32'hDEADBEEF;
    rst = 1'b1;
    drive(0, 0, 0, '0, 0, 0, 0, '0, 0);
    @(posedge clk); #1;

    // Requests during reset must not be granted
    drive(1, 1, 5, 32'h1111, 1, 1, 6, 32'h2222, 1);
    tick(); tick();
    rst = 1'b0;
    drive(0, 0, 0, '0, 0, 0, 0, '0, 0);
    tick();
    gntLog.delete();

    // Lone m0 read
    drive(1, 0, 'h010, '0, 0, 0, 0, '0, 0);
    tick();
    drive(0, 0, 0, '0, 0, 0, 0, '0, 0);
    tick();
    chk("lone_read_hold", bus.m0_rdata, 32'hDEADBEEF);
    logChk("lone_read", "10");

    // Continuous contention after reset alternates, m0 first
    rst = 1'b1; tick(); rst = 1'b0;
    gntLog.delete();
    drive(1, 0, 'h011, '0, 1, 0, 'h012, '0, 0);
    repeat (4) tick();
    logChk("alternate", "1212");

    // Locked m1 writes hold off m0 for eight grants
    drive(0, 0, 0, '0, 1, 1, 'h030, 32'hCAFE0001, 1);
    tick();
    drive(1, 0, 'h031, '0, 1, 1, 'h030, 32'hCAFE0001, 1);
    repeat (8) tick();
    logChk("lock8", "222222221");

    // Write by m0, read back by m1
    drive(1, 1, 'h020, 32'h12345678, 0, 0, 0, '0, 0);
    tick();
    drive(0, 0, 0, '0, 1, 0, 'h020, '0, 0);
    tick();
    drive(0, 0, 0, '0, 0, 0, 0, '0, 0);
    tick();
    chk("wr_rd_hold", bus.m1_rdata, 32'h12345678);
    logChk("wr_rd", "120");

    // Reset right after a read grant suppresses its rvalid
    drive(1, 0, 'h010, '0, 0, 0, 0, '0, 0);
    tick();
    rst = 1'b1;
    drive(1, 0, 'h010, '0, 1, 0, 'h011, '0, 0);
    tick();
    rst = 1'b0;
    tick();
    logChk("rst_after_read", "101");
    drive(0, 0, 0, '0, 0, 0, 0, '0, 0);
    tick();

    // Random contention; pending requests mostly held until granted
    for (int c = 0; c < 1000; c++) begin
      if (!(bus.m0_req && lastW != 1 && $urandom_range(0, 19) != 0)) begin
        bus.m0_req = 1'($urandom_range(0, 1)); bus.m0_we = 1'($urandom_range(0, 1));
        bus.m0_addr = AW'($urandom_range(0, 31)); bus.m0_wdata = $urandom;
      end
      if (!(bus.m1_req && lastW != 2 && $urandom_range(0, 19) != 0)) begin
        bus.m1_req = 1'($urandom_range(0, 1)); bus.m1_we = 1'($urandom_range(0, 1));
        bus.m1_addr = AW'($urandom_range(0, 31)); bus.m1_wdata = $urandom;
        bus.m1_lock = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    drive(0, 0, 0, '0, 0, 0, 0, '0, 0);
    tick(); tick();

    checks++;
    if (maxWait > 9) begin
      errors++;
      $display("FAIL max_wait: got %0d want <= 9", maxWait);
    end
    chk("queue_drained", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
